// File: rtl/seg_scan_capture_pkg.sv
// seg_capture_pkg: glyph table, dwell FSM encoding and segment bit indices
// shared by the seg_scan_capture block and its hex decoder.
package seg_capture_pkg;

    // Bit position of the decimal point inside an 8-bit segment pattern.
    localparam int SEG_DP = 7;

    // Active-low glyphs with the decimal point off (bit7 = 1).
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    // Dwell FSM: waiting for a single active anode, counting a stable
    // sample, or holding after a commit until the sample changes.
    typedef enum logic [1:0] {
        DW_WAIT  = 2'd0,
        DW_COUNT = 2'd1,
        DW_HELD  = 2'd2
    } dwell_state_e;

endpackage

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: board-side scan lines in, reconstructed display out.
// Protocol: there is no valid/ready handshake. seg/an/clr are sampled on
// every clk edge with no backpressure; the digit outputs hold their last
// committed value, frame_done is a single-cycle pulse, scan_error and
// display_stale are levels. dbg_state exposes the dwell FSM state.
interface seg_scan_capture_if #(
    parameter int SEG_COUNT = 4
);
    logic [7:0]             seg;
    logic [SEG_COUNT-1:0]   an;
    logic                   clr;
    logic [8*SEG_COUNT-1:0] digit_seg;
    logic [4*SEG_COUNT-1:0] digit_hex;
    logic [SEG_COUNT-1:0]   digit_valid;
    logic                   frame_done;
    logic                   scan_error;
    logic                   display_stale;
    logic [1:0]             dbg_state;

    modport master (
        output seg, an, clr,
        input  digit_seg, digit_hex, digit_valid, frame_done, scan_error,
               display_stale, dbg_state
    );

    modport slave (
        input  seg, an, clr,
        output digit_seg, digit_hex, digit_valid, frame_done, scan_error,
               display_stale, dbg_state
    );
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: maps an active-low 7-segment pattern to a hex nibble.
// The decimal point is ignored; unknown patterns give valid=0, nibble=0.
module seg_hex_decode
    import seg_capture_pkg::*;
(
    input  logic [7:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);

    logic [7:0] masked;

    // Force dp off, then look the glyph up in the table.
    always_comb begin
        masked         = pattern;
        masked[SEG_DP] = 1'b1;
        valid          = 1'b1;
        nibble         = 4'h0;
        case (masked)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: begin
                valid  = 1'b0;
                nibble = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed seg/an display, commits a digit
// once its sample has been stable for STABLE_CYCLES, decodes it to hex,
// and reports frames, multi-anode faults and a stalled display.
// Optional build macro: SEG_SCAN_CAPTURE_ACTIVE_HIGH_EN treats seg/an as
// active-high at the pins; everything after the input stage is active-low.
module seg_scan_capture
    import seg_capture_pkg::*;
#(
    parameter int SEG_COUNT      = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    seg_scan_capture_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

    localparam logic [1:0] S_WAIT  = DW_WAIT;
    localparam logic [1:0] S_COUNT = DW_COUNT;
    localparam logic [1:0] S_HELD  = DW_HELD;

    logic [7:0]             s_seg, p_seg;
    logic [SEG_COUNT-1:0]   s_an, p_an;
    logic [1:0]             state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   commit;
    logic [IW-1:0]          idx;
    int unsigned            low_cnt;
    logic                   is_active, is_multi, same;
    logic                   dec_valid;
    logic [3:0]             dec_nibble;
    logic [8*SEG_COUNT-1:0] dig_seg;
    logic [4*SEG_COUNT-1:0] dig_hex;
    logic [SEG_COUNT-1:0]   dig_valid;
    logic [SEG_COUNT-1:0]   seen, seen_set;
    logic                   frame_done_r, scan_error_r;
    logic [TW-1:0]          tcnt;

    // Register the pins once, and keep the previous sample for change detect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_seg <= 8'hFF;
            s_an  <= '1;
            p_seg <= 8'hFF;
            p_an  <= '1;
        end else begin
`ifdef SEG_SCAN_CAPTURE_ACTIVE_HIGH_EN
            s_seg <= ~bus.seg;
            s_an  <= ~bus.an;
`else
            s_seg <= bus.seg;
            s_an  <= bus.an;
`endif
            p_seg <= s_seg;
            p_an  <= s_an;
        end
    end

    // Classify the sampled anodes: one low = active digit, several = fault.
    always_comb begin
        low_cnt = 0;
        idx     = '0;
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (!s_an[i]) begin
                low_cnt = low_cnt + 1;
                idx     = IW'(i);
            end
        end
        is_active = (low_cnt == 1);
        is_multi  = (low_cnt > 1);
        same      = (s_seg == p_seg) && (s_an == p_an);
    end

    // Dwell FSM next state: count identical samples, commit once per run.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (!is_active) begin
            state_n = S_WAIT;
            cnt_n   = '0;
        end else if (state == S_HELD && same) begin
            state_n = S_HELD;
        end else begin
            if (state == S_COUNT && same) begin
                cnt_n = cnt + 1'b1;
            end else begin
                cnt_n = CW'(1);
            end
            if (cnt_n == CW'(STABLE_CYCLES)) begin
                commit  = 1'b1;
                state_n = S_HELD;
            end else begin
                state_n = S_COUNT;
            end
        end
    end

    // Dwell FSM state register; reset discards any partial dwell.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    seg_hex_decode u_dec (
        .pattern (s_seg),
        .valid   (dec_valid),
        .nibble  (dec_nibble)
    );

    // Write the committed pattern and its decode into the active slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dig_seg   <= '1;
            dig_hex   <= '0;
            dig_valid <= '0;
        end else if (commit) begin
            dig_seg[8*idx +: 8] <= s_seg;
            dig_hex[4*idx +: 4] <= dec_nibble;
            dig_valid[idx]      <= dec_valid;
        end
    end

    // Seen mask including this cycle's commit.
    always_comb begin
        seen_set = seen;
        if (commit) begin
            seen_set[idx] = 1'b1;
        end
    end

    // Frame tracking: pulse and restart once every digit has committed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seen         <= '0;
            frame_done_r <= 1'b0;
        end else if (bus.clr) begin
            seen         <= '0;
            frame_done_r <= 1'b0;
        end else if (&seen_set) begin
            seen         <= '0;
            frame_done_r <= 1'b1;
        end else begin
            seen         <= seen_set;
            frame_done_r <= 1'b0;
        end
    end

    // Sticky scan fault; a fault in the same cycle as clr keeps it set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_error_r <= 1'b0;
        end else if (is_multi) begin
            scan_error_r <= 1'b1;
        end else if (bus.clr) begin
            scan_error_r <= 1'b0;
        end
    end

    // Saturating timeout since the last commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (commit) begin
            tcnt <= '0;
        end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign bus.digit_seg     = dig_seg;
    assign bus.digit_hex     = dig_hex;
    assign bus.digit_valid   = dig_valid;
    assign bus.frame_done    = frame_done_r;
    assign bus.scan_error    = scan_error_r;
    assign bus.display_stale = (tcnt == TW'(TIMEOUT_CYCLES));
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed checks from the test plan plus a random
// scan phase, all compared every cycle against a run-length model.
module tb_seg_scan_capture;

    localparam int NSEG   = 4;
    localparam int STABLE = 16;
    localparam int TMO    = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_capture_if #(.SEG_COUNT(NSEG)) bus ();

    seg_scan_capture #(
        .SEG_COUNT      (NSEG),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic chk_en = 1'b0;

    // Logical (active-low) view of what is being driven.
    logic [7:0]      lg_seg = 8'hFF;
    logic [NSEG-1:0] lg_an  = '1;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                   8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                   8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [4:0] ref_decode(input logic [7:0] p);
        logic [7:0] q;
        q = {1'b1, p[6:0]};
        for (int g = 0; g < 16; g++) begin
            if (glyph_tab[g] == q) return {1'b1, 4'(g)};
        end
        return 5'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [NSEG-1:0] a, input logic [7:0] s);
        lg_an  = a;
        lg_seg = s;
`ifdef SEG_SCAN_CAPTURE_ACTIVE_HIGH_EN
        bus.an  = ~a;
        bus.seg = ~s;
`else
        bus.an  = a;
        bus.seg = s;
`endif
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in('0, 8'h00);
        wait_n(3);
        chk_en = 1'b1;
        chk("rst_digit_seg", 64'(bus.digit_seg), 64'h0000_0000_FFFF_FFFF);
        chk("rst_digit_valid", 64'(bus.digit_valid), 64'h0);
        chk("rst_flags", 64'({bus.frame_done, bus.scan_error, bus.display_stale}), 64'h0);
        set_in('1, 8'hFF);
        rst = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]      m_seg [NSEG];
    logic [3:0]      m_hex [NSEG];
    logic            m_val [NSEG];
    logic [NSEG-1:0] m_seen, set_mask;
    logic            m_fd, m_err;
    int              m_t, run, zeros, p_idx;
    logic [7:0]      last_seg, p_seg;
    logic [NSEG-1:0] last_an;
    logic            p_commit, p_multi;
    logic [4:0]      dv;

    // A digit commits one edge after the 16th identical single-anode sample
    // is presented (the extra edge is the pin register).
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NSEG; i++) begin
                m_seg[i] = 8'hFF; m_hex[i] = 4'h0; m_val[i] = 1'b0;
            end
            m_seen = '0; m_fd = 1'b0; m_err = 1'b0; m_t = 0; run = 0;
            last_seg = 8'hFF; last_an = '1; p_commit = 1'b0; p_multi = 1'b0;
            p_idx = 0; p_seg = 8'hFF;
        end else begin
            set_mask = m_seen;
            if (p_commit) begin
                m_seg[p_idx] = p_seg;
                dv = ref_decode(p_seg);
                m_val[p_idx] = dv[4];
                m_hex[p_idx] = dv[3:0];
                set_mask[p_idx] = 1'b1;
            end
            if (bus.clr) begin
                m_seen = '0; m_fd = 1'b0;
            end else if (set_mask == '1) begin
                m_seen = '0; m_fd = 1'b1;
            end else begin
                m_seen = set_mask; m_fd = 1'b0;
            end
            if (p_multi) m_err = 1'b1;
            else if (bus.clr) m_err = 1'b0;
            if (p_commit) m_t = 0;
            else if (m_t < TMO) m_t = m_t + 1;

            zeros = 0;
            for (int i = 0; i < NSEG; i++) begin
                if (!lg_an[i]) begin
                    zeros++;
                    p_idx = i;
                end
            end
            if (zeros == 1 && lg_seg == last_seg && lg_an == last_an) run++;
            else run = (zeros == 1) ? 1 : 0;
            p_commit = (zeros == 1) && (run == STABLE);
            p_multi  = (zeros > 1);
            p_seg    = lg_seg;
            last_seg = lg_seg;
            last_an  = lg_an;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin : cmp
            logic [8*NSEG-1:0] es;
            logic [4*NSEG-1:0] eh;
            logic [NSEG-1:0]   ev;
            for (int i = 0; i < NSEG; i++) begin
                es[8*i +: 8] = m_seg[i];
                eh[4*i +: 4] = m_hex[i];
                ev[i]        = m_val[i];
            end
            chk("digit_seg", 64'(bus.digit_seg), 64'(es));
            chk("digit_hex", 64'(bus.digit_hex), 64'(eh));
            chk("digit_valid", 64'(bus.digit_valid), 64'(ev));
            chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
            chk("scan_error", 64'(bus.scan_error), 64'(m_err));
            chk("display_stale", 64'(bus.display_stale), 64'(m_t == TMO));
            if (bus.frame_done) fd_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k1, k2, kind, dwell;
        logic [NSEG-1:0] a;
        logic [7:0] s;

        bus.clr = 1'b0;
        set_in('0, 8'h00);
        @(negedge clk);
        do_reset();

        // Normal scan: digits 0..2, then watch digit3's commit edge closely.
        fd_cnt = 0;
        set_in(4'hE, 8'hF9); wait_n(20);
        set_in(4'hD, 8'hA4); wait_n(20);
        set_in(4'hB, 8'hB0); wait_n(20);
        set_in(4'h7, 8'h99); wait_n(16);
        chk("scan_valid_pre", 64'(bus.digit_valid), 64'h7);
        chk("scan_fd_pre", 64'(bus.frame_done), 64'h0);
        wait_n(1);
        chk("scan_valid", 64'(bus.digit_valid), 64'hF);
        chk("scan_hex", 64'(bus.digit_hex), 64'h4321);
        chk("scan_fd_pulse", 64'(bus.frame_done), 64'h1);
        wait_n(3);
        chk("scan_fd_count", 64'(fd_cnt), 64'd1);

        // Glitch rejection.
        do_reset();
        set_in(4'hE, 8'hC0); wait_n(10);
        chk("glitch_no_commit", 64'(bus.digit_seg[7:0]), 64'hFF);
        set_in(4'hE, 8'hF9); wait_n(20);
        chk("glitch_seg", 64'(bus.digit_seg[7:0]), 64'hF9);
        chk("glitch_hex", 64'(bus.digit_hex[3:0]), 64'h1);

        // Undecodable pattern, then '0' with dp lit.
        set_in(4'hE, 8'h7F); wait_n(20);
        chk("undec_seg", 64'(bus.digit_seg[7:0]), 64'h7F);
        chk("undec_valid", 64'(bus.digit_valid[0]), 64'h0);
        chk("undec_hex", 64'(bus.digit_hex[3:0]), 64'h0);
        set_in(4'hE, 8'h40); wait_n(20);
        chk("dp0_valid", 64'(bus.digit_valid[0]), 64'h1);
        chk("dp0_hex", 64'(bus.digit_hex[3:0]), 64'h0);

        // Scan fault, clear, then fault coinciding with clear.
        set_in(4'hC, 8'hC0); wait_n(5);
        chk("multi_err", 64'(bus.scan_error), 64'h1);
        chk("multi_no_commit", 64'(bus.digit_seg), 64'hFFFF_FF40);
        set_in(4'hF, 8'hFF); wait_n(2);
        bus.clr = 1'b1; wait_n(1); bus.clr = 1'b0;
        chk("clr_err", 64'(bus.scan_error), 64'h0);
        set_in(4'hC, 8'hC0); bus.clr = 1'b1; wait_n(3);
        chk("multi_clr_err", 64'(bus.scan_error), 64'h1);
        bus.clr = 1'b0;
        set_in(4'hF, 8'hFF); wait_n(2);

        // Stale display.
        do_reset();
        set_in(4'hF, 8'hFF); wait_n(63);
        chk("stale_63", 64'(bus.display_stale), 64'h0);
        wait_n(1);
        chk("stale_64", 64'(bus.display_stale), 64'h1);
        wait_n(6);
        set_in(4'hE, 8'h99); wait_n(16);
        chk("stale_precommit", 64'(bus.display_stale), 64'h1);
        chk("latency_pre", 64'(bus.digit_valid[0]), 64'h0);
        wait_n(1);
        chk("stale_cleared", 64'(bus.display_stale), 64'h0);
        chk("latency_hex", 64'(bus.digit_hex[3:0]), 64'h4);

        // Random scan traffic, with one reset mid-dwell.
        for (int n = 0; n < 160; n++) begin
            kind = $urandom_range(0, 99);
            k1 = $urandom_range(0, NSEG - 1);
            k2 = (k1 + $urandom_range(1, NSEG - 1)) % NSEG;
            if (kind < 70)      a = ~(4'b1 << k1);
            else if (kind < 85) a = '1;
            else                a = ~((4'b1 << k1) | (4'b1 << k2));
            if ($urandom_range(0, 9) < 7) begin
                s = glyph_tab[$urandom_range(0, 15)];
                s[7] = 1'($urandom_range(0, 1));
            end else begin
                s = 8'($urandom);
            end
            dwell = $urandom_range(1, 24);
            set_in(a, s);
            if ($urandom_range(0, 9) == 0) begin
                bus.clr = 1'b1; wait_n(1); bus.clr = 1'b0;
                dwell = (dwell > 1) ? dwell - 1 : 1;
            end
            if (n == 80) begin
                wait_n(8);
                rst = 1'b0; wait_n(2); rst = 1'b1;
                set_in(a, s);
            end
            wait_n(dwell);
        end
        wait_n(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
Reader for the multiplexed 7-segment interface that a user design drives (seg/an) on the virtual board. Samples the scanned seg/an lines and rejects transitions by requiring a stable dwell. Reconstructs the per-digit segment patterns and decodes them to hex nibbles for the GUI and the bench. Flags scan faults (multiple anodes active) and a stalled display.

Parameters:
SEG_COUNT, 4, number of digits/anodes
STABLE_CYCLES, 16, consecutive identical samples required to commit a digit (>=2)
TIMEOUT_CYCLES, 65536, cycles without a commit before display_stale asserts

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
seg  input  8  segment lines; bit0=a … bit6=g, bit7=dp; active-low
an  input  SEG_COUNT  anode lines; one-hot active-low; bit i = digit i
clr  input  1  synchronous clear of scan_error and the frame-seen mask
digit_seg  output  8*SEG_COUNT  last committed raw pattern per digit; slice [8i+7:8i] = digit i
digit_hex  output  4*SEG_COUNT  decoded nibble per digit; 0 if not decodable
digit_valid  output  SEG_COUNT  1 = committed pattern (dp ignored) matches a hex glyph
frame_done  output  1  one-cycle pulse when every digit has committed since the last frame
scan_error  output  1  sticky; set when more than one anode is active
display_stale  output  1  no commit for TIMEOUT_CYCLES

Behaviour:
- Reset (rst=0 at a clk edge):
  - digit_seg = all 1s (blank); digit_hex = 0; digit_valid = 0.
  - frame_done = 0; scan_error = 0; display_stale = 0.
  - Dwell counter, seen mask and timeout counter cleared.
  - Reset mid-dwell discards the partial dwell.
- Input stage: seg/an registered once (s_seg/s_an). All logic uses the registered copy.
- Anode classification of s_an:
  - exactly one bit low → ACTIVE(idx);
  - none low → IDLE;
  - more than one low → MULTI.
- Dwell FSM (states WAIT, COUNT, HELD):
  - WAIT: ACTIVE sample → COUNT, cnt=1.
  - COUNT: sample equal to previous (seg and an) → cnt++. Change → cnt=1 if ACTIVE, else WAIT.
  - When cnt reaches STABLE_CYCLES: commit s_seg into slot idx, update hex/valid, set seen[idx]; → HELD.
  - HELD: no further commit until the sample changes. Change → COUNT (ACTIVE) or WAIT.
  - IDLE or MULTI in any state → WAIT.
  - MULTI also sets scan_error. Nothing is committed during MULTI.
- Latency: a value first present on seg/an before edge k is visible on digit_seg/digit_hex/digit_valid after edge k+STABLE_CYCLES.
- Frame tracking:
  - On the cycle that seen becomes all-ones, including via the commit in that cycle, frame_done=1 for exactly one cycle and seen clears.
  - A recommit of an already-seen digit does not pulse.
- clr: clears scan_error and seen. A commit in the same cycle still updates digit outputs but its seen bit is dropped (clr wins). MULTI coinciding with clr leaves scan_error=1.
- Timeout counter:
  - increments every cycle and saturates at TIMEOUT_CYCLES;
  - display_stale=1 while saturated;
  - a commit zeros the counter and display_stale deasserts on the next edge.
- Hex decode (dp masked off), seg[7:0] values with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - any other pattern → valid=0, hex=0.

Optional Feature:
SEG_SCAN_CAPTURE_ACTIVE_HIGH_EN
- Defined: seg and an are treated as active-high. Both are inverted at the input stage; all internal logic and the digit_seg encoding stay active-low.
- Undefined: active-low as specified above.

Decomposition:
- Package seg_capture_pkg:
  - 16 glyph constants (8-bit, active-low);
  - dwell FSM state enum (WAIT/COUNT/HELD);
  - SEG_DP index constant.
- Sub-module seg_hex_decode: combinational 8-bit pattern → {valid, nibble}, instantiated once per committed slot or shared at the commit point.

Test Plan:
- Reset: hold rst=0 for 3 cycles with seg=00, an=0 → digit_seg all FF, digit_valid=0, all flags 0.
- Normal scan, dwell 20 cycles each: an=E/seg=F9, an=D/seg=A4, an=B/seg=B0, an=7/seg=99 → digit_hex=4'h4,3,2,1 (digit3..0), valid=F. Each digit commits 16 cycles after its dwell begins. frame_done pulses once, on digit3's commit.
- Glitch rejection: an=E, seg=C0 for 10 cycles, then seg=F9 for 20 → digit0 commits F9 (hex 1) only; C0 is never committed.
- Undecodable pattern: an=E, seg=7F (dp only on) held 20 cycles → digit_seg[7:0]=7F, digit_valid[0]=0, digit_hex[3:0]=0. Then seg=40 ('0' with dp) → valid[0]=1, hex=0.
- Scan fault: an=C for 5 cycles → scan_error=1, no commit. Pulse clr → scan_error=0. Repeat an=C together with clr → scan_error stays 1.
- Stale (TIMEOUT_CYCLES=64): an=F for 70 cycles → display_stale=1 from cycle 64. Then a valid 16-cycle dwell → display_stale=0 the cycle after the commit.
